// File: rtl/des_text_packer.sv
// des_text_packer: packs an ASCII byte stream MSB-first into 64-bit DES
// plaintext blocks, pads the final block and hands each block downstream
// on a valid/ready interface that also drives the encryptor enable.
// Build option: define PKCS_PAD_EN for PKCS#5 padding. This adds an extra
// all-0x08 block after a message that ends on a block boundary. Without the
// macro, pad bytes are 0x00.
module des_text_packer #(
  parameter int CNT_W      = 16,
  parameter int PAD_BYTE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAD_BYTE_W-1:0] in_byte,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [63:0]           value,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic                  blk_last,
  output logic                  encr_en,
  output logic [CNT_W-1:0]      blk_count
);

`ifdef PKCS_PAD_EN
  localparam bit PKCS_EN = 1'b1;
`else
  localparam bit PKCS_EN = 1'b0;
`endif

  localparam logic [63:0] PAD_BLOCK = 64'h0808080808080808;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [63:0]             value_q, value_d;
  logic                    last_q, last_d;
  logic                    extra_q, extra_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              n_used;
  logic [PAD_BYTE_W-1:0]   pad_byte;

  // Pad byte for a block holding n data bytes: 8-n under PKCS#5, else zero.
  function automatic logic [PAD_BYTE_W-1:0] pad_val(input logic [3:0] n);
    pad_val = PKCS_EN ? PAD_BYTE_W'(4'd8 - n) : '0;
  endfunction

  assign n_used   = {1'b0, idx_q} + 4'd1;
  assign pad_byte = pad_val(n_used);

  // The block interface is a pure decode of the registered FSM state.
  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == OUT);
  assign encr_en   = (state_q == OUT);
  assign value     = value_q;
  assign blk_last  = last_q;
  assign blk_count = cnt_q;

  // Next-state logic: byte packing and padding in FILL, block hand-off in OUT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    value_d = value_q;
    last_d  = last_q;
    extra_d = extra_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          // Current byte goes to its lane; on the last byte every later
          // lane is filled with the pad value in the same cycle.
          for (int i = 0; i < 8; i++) begin
            if (3'(i) == idx_q) begin
              value_d[63-8*i -: 8] = in_byte;
            end else if (in_last && (3'(i) > idx_q)) begin
              value_d[63-8*i -: 8] = pad_byte;
            end
          end
          idx_d = idx_q + 3'd1;
          if (in_last) begin
            state_d = OUT;
            idx_d   = 3'd0;
            if (idx_q == 3'd7) begin
              // Boundary-aligned end: under PKCS#5 the final marker moves
              // to the extra pad block that follows.
              last_d  = !PKCS_EN;
              extra_d = PKCS_EN;
            end else begin
              last_d = 1'b1;
            end
          end else if (idx_q == 3'd7) begin
            state_d = OUT;
            last_d  = 1'b0;
          end
        end
      end
      OUT: begin
        if (blk_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (extra_q) begin
            value_d = PAD_BLOCK;
            last_d  = 1'b1;
            extra_d = 1'b0;
          end else begin
            state_d = FILL;
            idx_d   = 3'd0;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State registers; reset discards any partial or pending block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= 3'd0;
      value_q <= 64'd0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      last_q  <= last_d;
      extra_q <= extra_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_des_text_packer.sv
// Self-checking bench for des_text_packer. The reference model turns whole
// messages into expected blocks by chunking and padding. It tracks how many
// completed blocks still wait for hand-off, and it never looks at DUT state.
module tb_des_text_packer;

  localparam int CW = 4;  // small counter so the wrap is reached quickly

`ifdef PKCS_PAD_EN
  localparam bit PKCS = 1'b1;
`else
  localparam bit PKCS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [63:0]   value;
  logic          blk_valid;
  logic          blk_ready;
  logic          blk_last;
  logic          encr_en;
  logic [CW-1:0] blk_count;

  des_text_packer #(.CNT_W(CW), .PAD_BYTE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .value     (value),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_last  (blk_last),
    .encr_en   (encr_en),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] b; logic l;} src_t;
  typedef struct packed {logic [63:0] v; logic l;} blk_t;

  src_t src_q[$];
  blk_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   pending = 0;   // completed blocks not yet handed off
  int   nbytes = 0;    // bytes accepted into the current block
  int   hs_cnt = 0;
  int   vld_pct = 100;
  int   rdy_pct = 100;
  int   hold = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Message -> expected blocks, straight from the padding rules.
  task automatic enqueue(input logic [7:0] m[$]);
    int len;
    len = m.size();
    for (int i = 0; i < len; i += 8) begin
      int n;
      logic [63:0] blk;
      n = (len - i < 8) ? len - i : 8;
      blk = 64'd0;
      for (int j = 0; j < 8; j++) begin
        logic [7:0] b;
        b = (j < n) ? m[i+j] : (PKCS ? 8'(8 - n) : 8'h00);
        blk = {blk[55:0], b};
      end
      exp_q.push_back(blk_t'{v: blk, l: (i + 8 >= len) && !(n == 8 && PKCS)});
    end
    if (len % 8 == 0 && PKCS) exp_q.push_back(blk_t'{v: 64'h0808080808080808, l: 1'b1});
    for (int k = 0; k < len; k++) src_q.push_back(src_t'{b: m[k], l: (k == len - 1)});
  endtask

  // One clock: check outputs at negedge, drive inputs, advance the model.
  task automatic cycle();
    logic exp_valid;
    logic acc, hs;
    src_t s;
    exp_valid = (pending > 0);
    chk("blk_valid", blk_valid, exp_valid);
    chk("encr_en", encr_en, exp_valid);
    chk("in_ready", in_ready, !exp_valid);
    chk("blk_count", blk_count, 64'(hs_cnt % (1 << CW)));
    if (exp_valid && exp_q.size() > 0) begin
      chk("value", value, exp_q[0].v);
      chk("blk_last", blk_last, exp_q[0].l);
    end
    if (src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      in_valid = 1'b1;
      in_byte  = src_q[0].b;
      in_last  = src_q[0].l;
    end else begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      in_last  = 1'($urandom_range(1));
    end
    if (exp_valid && hold > 0) begin
      blk_ready = 1'b0;
      hold--;
    end else begin
      blk_ready = ($urandom_range(99) < rdy_pct);
    end
    acc = in_valid && !exp_valid;
    hs  = blk_ready && exp_valid;
    if (hs) begin
      void'(exp_q.pop_front());
      pending--;
      hs_cnt++;
    end
    if (acc) begin
      s = src_q.pop_front();
      nbytes++;
      if (nbytes == 8 || s.l) begin
        pending += (nbytes == 8 && s.l && PKCS) ? 2 : 1;
        nbytes = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int c;
    c = 0;
    while ((src_q.size() > 0 || pending > 0) && c < bound) begin
      cycle();
      c++;
    end
    chk("drain_done", 64'(src_q.size() + pending), 64'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    src_q.delete();
    exp_q.delete();
    pending = 0;
    nbytes  = 0;
    hs_cnt  = 0;
    chk("rst_value", value, 64'd0);
    chk("rst_blk_last", blk_last, 1'b0);
    chk("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_encr_en", encr_en, 1'b0);
    chk("rst_blk_count", blk_count, 64'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m[$];
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    do_reset();

    // Boundary-aligned message 0x41..0x48
    m = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    enqueue(m);
    drain(100);

    // Two-byte message
    m = {8'h48, 8'h49};
    enqueue(m);
    drain(100);

    // Single byte: one data byte and seven pad bytes
    m = {8'h5A};
    enqueue(m);
    drain(100);

    // Backpressure on a full block
    m = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    hold = 5;
    enqueue(m);
    drain(100);

    // Reset after three bytes, then a clean block
    m = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    enqueue(m);
    repeat (3) cycle();
    do_reset();
    m = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    enqueue(m);
    drain(100);

    // Aligned message followed by idle cycles
    m = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    enqueue(m);
    drain(100);
    repeat (4) cycle();

    // Random messages with random gaps and backpressure
    for (int r = 0; r < 40; r++) begin
      vld_pct = $urandom_range(100, 30);
      rdy_pct = $urandom_range(100, 20);
      hold    = ($urandom_range(3) == 0) ? $urandom_range(6, 1) : 0;
      for (int k = 0; k < 2; k++) begin
        int len;
        len = $urandom_range(20, 1);
        m.delete();
        for (int j = 0; j < len; j++) m.push_back(8'($urandom_range(126, 32)));
        enqueue(m);
      end
      drain(2000);
    end
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
